// File: rtl/spi_txn_arbiter.sv
// Round-robin arbiter sharing one spi_controller among NUM_REQ requesters,
// with a one-entry inbound capture buffer carrying sticky overflow.
module spi_txn_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int GUARD   = 2,
  parameter int TIMEOUT = 4096
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_REQ-1:0]    req,
  input  logic [32*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]    grant,
  output logic [NUM_REQ-1:0]    done,
  output logic [NUM_REQ-1:0]    err,
  output logic                  ctrl_trigger_out,
  output logic [31:0]           ctrl_to_device,
  input  logic                  ctrl_spi_cs,
  input  logic [31:0]           ctrl_from_device,
  input  logic                  ctrl_from_device_rdy,
  output logic [31:0]           rx_data,
  output logic                  rx_valid,
  input  logic                  rx_ready,
  output logic                  rx_overflow,
  input  logic                  rx_overflow_clr
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int GW = $clog2(GUARD + 2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARB,
    S_TRIG,
    S_WSTART,
    S_WDONE,
    S_ACK,
    S_ERR
  } state_e;

  state_e               state_q, state_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic [IW-1:0]        ptr_q, ptr_d;
  logic [31:0]          tx_q, tx_d;
  logic [GW-1:0]        guard_q, guard_d;
  logic [15:0]          tmo_q, tmo_d;
  logic [31:0]          rx_data_q, rx_data_d;
  logic                 rx_valid_q, rx_valid_d;
  logic                 ovf_q, ovf_d;
  logic                 rdy_q;
  logic                 rdy_rise;

  logic [IW-1:0]        win;
  logic [NUM_REQ-1:0]   win_oh;
  logic                 found;
  logic [IW:0]          sum;
  logic [IW-1:0]        idx;

  // First requester after the last winner, with wrap-around
  always_comb begin
    win   = '0;
    found = 1'b0;
    sum   = '0;
    idx   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      sum = {1'b0, ptr_q} + (IW+1)'(k);
      if (sum >= (IW+1)'(NUM_REQ)) sum = sum - (IW+1)'(NUM_REQ);
      idx = sum[IW-1:0];
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
    win_oh      = '0;
    win_oh[win] = 1'b1;
  end

  // Completion restarts the guard window so done-to-ARB spacing holds
  always_comb begin
    guard_d = guard_q;
    if (state_q == S_ACK || state_q == S_ERR) guard_d = '0;
    else if (!ctrl_spi_cs) guard_d = '0;
    else if (guard_q != GW'(GUARD)) guard_d = guard_q + 1'b1;
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    tx_d    = tx_q;
    tmo_d   = tmo_q;
    unique case (state_q)
      S_IDLE: begin
        if (|req && guard_q == GW'(GUARD)) state_d = S_ARB;
      end
      S_ARB: begin
        if (found) begin
          grant_d = win_oh;
          tx_d    = req_data[{win, 5'd0} +: 32];
          ptr_d   = win;
          state_d = S_TRIG;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_TRIG: begin
        tmo_d   = '0;
        state_d = S_WSTART;
      end
      S_WSTART: begin
        if (!ctrl_spi_cs) begin
          state_d = S_WDONE;
        end else begin
          tmo_d = tmo_q + 1'b1;
          if ({1'b0, tmo_q} + 17'd2 >= 17'(TIMEOUT)) state_d = S_ERR;
        end
      end
      S_WDONE: begin
        if (ctrl_spi_cs) state_d = S_ACK;
      end
      S_ACK, S_ERR: begin
        grant_d = '0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign rdy_rise = ctrl_from_device_rdy & ~rdy_q;

  always_comb begin
    rx_data_d  = rx_data_q;
    rx_valid_d = rx_valid_q;
    ovf_d      = ovf_q;
    if (rdy_rise) begin
      if (!rx_valid_q || rx_ready) begin
        rx_data_d  = ctrl_from_device;
        rx_valid_d = 1'b1;
      end
    end else if (rx_ready) begin
      rx_valid_d = 1'b0;
    end
    if (rx_overflow_clr) ovf_d = 1'b0;
    if (rdy_rise && rx_valid_q && !rx_ready) ovf_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      grant_q    <= '0;
      ptr_q      <= IW'(NUM_REQ - 1);
      tx_q       <= '0;
      guard_q    <= '0;
      tmo_q      <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      ovf_q      <= 1'b0;
      rdy_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      ptr_q      <= ptr_d;
      tx_q       <= tx_d;
      guard_q    <= guard_d;
      tmo_q      <= tmo_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      ovf_q      <= ovf_d;
      rdy_q      <= ctrl_from_device_rdy;
    end
  end

  assign grant            = grant_q;
  assign done             = (state_q == S_ACK) ? grant_q : '0;
  assign err              = (state_q == S_ERR) ? grant_q : '0;
  assign ctrl_trigger_out = (state_q == S_TRIG) & ctrl_spi_cs;
  assign ctrl_to_device   = tx_q;
  assign rx_data          = rx_data_q;
  assign rx_valid         = rx_valid_q;
  assign rx_overflow      = ovf_q;

endmodule

// File: tb/tb_spi_txn_arbiter.sv
// Directed bench for spi_txn_arbiter: transfer table plus
// hand-written rx-buffer and reset sequences.
module tb_spi_txn_arbiter;

  localparam int NR  = 4;
  localparam int GRD = 2;
  localparam int TMO = 64;

  logic              clk;
  logic              rst_n;
  logic [NR-1:0]     req;
  logic [32*NR-1:0]  req_data;
  logic [NR-1:0]     grant;
  logic [NR-1:0]     done;
  logic [NR-1:0]     err;
  logic              ctrl_trigger_out;
  logic [31:0]       ctrl_to_device;
  logic              ctrl_spi_cs;
  logic [31:0]       ctrl_from_device;
  logic              ctrl_from_device_rdy;
  logic [31:0]       rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic              rx_overflow;
  logic              rx_overflow_clr;

  int n_chk  = 0;
  int n_fail = 0;

  spi_txn_arbiter #(
    .NUM_REQ(NR),
    .GUARD(GRD),
    .TIMEOUT(TMO)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .req(req),
    .req_data(req_data),
    .grant(grant),
    .done(done),
    .err(err),
    .ctrl_trigger_out(ctrl_trigger_out),
    .ctrl_to_device(ctrl_to_device),
    .ctrl_spi_cs(ctrl_spi_cs),
    .ctrl_from_device(ctrl_from_device),
    .ctrl_from_device_rdy(ctrl_from_device_rdy),
    .rx_data(rx_data),
    .rx_valid(rx_valid),
    .rx_ready(rx_ready),
    .rx_overflow(rx_overflow),
    .rx_overflow_clr(rx_overflow_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  req;
    int          dly;
    int          len;
    bit          tmo;
    bit          drop;
    logic [3:0]  gnt;
    logic [31:0] word;
  } vec_t;

  vec_t vt[9];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v);
    int n;
    req = v.req;
    n = 0;
    while (!ctrl_trigger_out && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk("trig_seen", 32'(ctrl_trigger_out), 32'd1);
    chk("grant", 32'(grant), 32'(v.gnt));
    chk("to_dev_at_trig", ctrl_to_device, v.word);
    @(negedge clk);
    chk("trig_pulse", 32'(ctrl_trigger_out), 32'd0);
    if (v.tmo) begin
      n = 1;
      while (err == '0 && n < TMO + 10) begin
        chk("no_done_tmo", 32'(done), 32'd0);
        @(negedge clk);
        n++;
      end
      chk("err_onehot", 32'(err), 32'(v.gnt));
      chk("err_delay", n, TMO);
      chk("no_done_at_err", 32'(done), 32'd0);
      @(negedge clk);
      chk("err_pulse", 32'(err), 32'd0);
      chk("grant_clr_err", 32'(grant), 32'd0);
    end else begin
      repeat (v.dly - 1) @(negedge clk);
      ctrl_spi_cs = 1'b0;
      for (int k = 0; k < v.len; k++) begin
        @(negedge clk);
        if (v.drop && k == v.len / 2) begin
          req = '0;
          req_data[95:64] = 32'hFFFF_0000;
        end
        chk("to_dev_hold", ctrl_to_device, v.word);
        chk("no_trig_cs_low", 32'(ctrl_trigger_out), 32'd0);
        chk("grant_hold", 32'(grant), 32'(v.gnt));
      end
      ctrl_spi_cs = 1'b1;
      n = 0;
      while (done == '0 && n < 6) begin
        @(negedge clk);
        n++;
      end
      chk("done_onehot", 32'(done), 32'(v.gnt));
      chk("no_err", 32'(err), 32'd0);
      @(negedge clk);
      chk("done_pulse", 32'(done), 32'd0);
      chk("grant_clr", 32'(grant), 32'd0);
      if (v.drop) req_data[95:64] = 32'h2222_0002;
    end
  endtask

  initial begin
    vt[0] = '{4'b1111, 3, 10, 1'b0, 1'b0, 4'b0001, 32'h1111_0000};
    vt[1] = '{4'b1111, 3, 10, 1'b0, 1'b0, 4'b0010, 32'hA5A5_0F0F};
    vt[2] = '{4'b1111, 3, 10, 1'b0, 1'b0, 4'b0100, 32'h2222_0002};
    vt[3] = '{4'b1111, 3, 10, 1'b0, 1'b0, 4'b1000, 32'h3333_0003};
    vt[4] = '{4'b1111, 3, 10, 1'b0, 1'b0, 4'b0001, 32'h1111_0000};
    vt[5] = '{4'b0010, 30, 1600, 1'b0, 1'b0, 4'b0010, 32'hA5A5_0F0F};
    vt[6] = '{4'b0100, 5, 20, 1'b0, 1'b1, 4'b0100, 32'h2222_0002};
    vt[7] = '{4'b1000, 0, 0, 1'b1, 1'b0, 4'b1000, 32'h3333_0003};
    vt[8] = '{4'b0001, 3, 10, 1'b0, 1'b0, 4'b0001, 32'h1111_0000};

    rst_n = 1'b0;
    req = '0;
    req_data = {32'h3333_0003, 32'h2222_0002, 32'hA5A5_0F0F, 32'h1111_0000};
    ctrl_spi_cs = 1'b1;
    ctrl_from_device = '0;
    ctrl_from_device_rdy = 1'b0;
    rx_ready = 1'b0;
    rx_overflow_clr = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_trig", 32'(ctrl_trigger_out), 32'd0);
    chk("rst_to_dev", ctrl_to_device, 32'd0);
    chk("rst_rx_valid", 32'(rx_valid), 32'd0);
    chk("rst_rx_ovf", 32'(rx_overflow), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 9; i++) run_vec(vt[i]);
    req = '0;
    repeat (4) @(negedge clk);

    // Inbound capture buffer
    ctrl_from_device = 32'h1234_5678;
    ctrl_from_device_rdy = 1'b1;
    @(negedge clk);
    chk("rx_cap_valid", 32'(rx_valid), 32'd1);
    chk("rx_cap_data", rx_data, 32'h1234_5678);
    ctrl_from_device = 32'hDEAD_BEEF;
    @(negedge clk);
    chk("rx_held_rdy_data", rx_data, 32'h1234_5678);
    chk("rx_held_rdy_ovf", 32'(rx_overflow), 32'd0);
    ctrl_from_device_rdy = 1'b0;
    @(negedge clk);
    ctrl_from_device_rdy = 1'b1;
    @(negedge clk);
    chk("rx_ovf_data", rx_data, 32'h1234_5678);
    chk("rx_ovf_set", 32'(rx_overflow), 32'd1);
    chk("rx_ovf_valid", 32'(rx_valid), 32'd1);
    ctrl_from_device_rdy = 1'b0;
    rx_ready = 1'b1;
    @(negedge clk);
    chk("rx_consumed", 32'(rx_valid), 32'd0);
    chk("rx_ovf_sticky", 32'(rx_overflow), 32'd1);
    rx_ready = 1'b0;
    rx_overflow_clr = 1'b1;
    @(negedge clk);
    chk("rx_ovf_clr", 32'(rx_overflow), 32'd0);
    rx_overflow_clr = 1'b0;
    ctrl_from_device = 32'h0BAD_F00D;
    ctrl_from_device_rdy = 1'b1;
    @(negedge clk);
    chk("rx_cap2_data", rx_data, 32'h0BAD_F00D);
    chk("rx_cap2_valid", 32'(rx_valid), 32'd1);
    ctrl_from_device_rdy = 1'b0;
    @(negedge clk);
    ctrl_from_device = 32'h1111_1111;
    ctrl_from_device_rdy = 1'b1;
    rx_overflow_clr = 1'b1;
    @(negedge clk);
    chk("rx_set_wins", 32'(rx_overflow), 32'd1);
    chk("rx_keep_old", rx_data, 32'h0BAD_F00D);
    ctrl_from_device_rdy = 1'b0;
    rx_overflow_clr = 1'b0;
    @(negedge clk);

    // Reset during WAIT_DONE
    req = 4'b0001;
    begin
      int n;
      n = 0;
      while (!ctrl_trigger_out && n < 60) begin
        @(negedge clk);
        n++;
      end
    end
    chk("rst_seq_trig", 32'(ctrl_trigger_out), 32'd1);
    @(negedge clk);
    ctrl_spi_cs = 1'b0;
    repeat (3) @(negedge clk);
    chk("pre_rst_grant", 32'(grant), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("async_grant", 32'(grant), 32'd0);
    chk("async_done", 32'(done), 32'd0);
    chk("async_err", 32'(err), 32'd0);
    chk("async_to_dev", ctrl_to_device, 32'd0);
    chk("async_rx_data", rx_data, 32'd0);
    chk("async_rx_valid", 32'(rx_valid), 32'd0);
    chk("async_rx_ovf", 32'(rx_overflow), 32'd0);
    req = '0;
    @(negedge clk);
    rst_n = 1'b1;
    ctrl_spi_cs = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      chk("post_rst_done", 32'(done), 32'd0);
      chk("post_rst_err", 32'(err), 32'd0);
      chk("post_rst_trig", 32'(ctrl_trigger_out), 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
